// File: rtl/axil_pkg.sv
// Shared types and default widths for the two-port AXI-Lite arbiter.
package axil_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    // Read path states: waiting, forwarding AR, forwarding R.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    // Write path states: waiting, forwarding AW/W, forwarding B.
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // Grant encoding: 0 selects s0, 1 selects s1.
    typedef logic grant_t;

endpackage

// File: rtl/axil_intf.sv
// AXI-Lite bundle without response codes. The master modport drives requests,
// the slave modport drives readies and responses.
interface axil_intf #(
    parameter int DATA_WIDTH = axil_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = axil_pkg::ADDR_WIDTH
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rvalid, input rready
    );

endinterface

// File: rtl/axil_arb2_sel.sv
// Two-way grant select. Default build is fixed priority (s0 wins ties).
// Defining AXIL_ARB_RR_EN adds a last-grant pointer for round-robin ties.
module axil_arb2_sel
    import axil_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req0,
    input  logic   req1,
    input  logic   load,
    output grant_t winner
);

`ifdef AXIL_ARB_RR_EN
    grant_t last;

    // Track the port granted at the most recent IDLE exit; reset value makes s0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (load) begin
            last <= winner;
        end
    end

    // A tie goes to the port that was not granted last; otherwise the lone requester.
    always_comb begin
        if (req0 && req1) begin
            winner = ~last;
        end else begin
            winner = req1 && !req0;
        end
    end
`else
    logic unused_sel;
    assign unused_sel = &{1'b0, clk, rst, load};

    // s0 wins every tie; s1 only when it requests alone.
    always_comb begin
        winner = req1 && !req0;
    end
`endif

endmodule

// File: rtl/axil_arb2.sv
// Two-requester AXI-Lite arbiter with independent read and write paths.
// Optional round-robin arbitration: define AXIL_ARB_RR_EN.
// Handshakes: a beat transfers on the rising edge where valid and ready are both 1;
// the arbiter only forwards valids/readies combinationally from the granted port.
module axil_arb2
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = axil_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = axil_pkg::ADDR_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    axil_intf.slave  s0,
    axil_intf.slave  s1,
    axil_intf.master m,
    output r_state_t r_state,
    output w_state_t w_state
);

    // ---------------- read path ----------------
    r_state_t r_next;
    grant_t   r_grant;
    grant_t   r_winner;
    logic     r_load;

    assign r_load = (r_state == R_IDLE) && (s0.arvalid || s1.arvalid);

    axil_arb2_sel u_rd_sel (
        .clk    (clk),
        .rst    (rst),
        .req0   (s0.arvalid),
        .req1   (s1.arvalid),
        .load   (r_load),
        .winner (r_winner)
    );

    // Read state and grant registers; grant is frozen until the FSM returns to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_grant <= 1'b0;
        end else begin
            r_state <= r_next;
            if (r_load) begin
                r_grant <= r_winner;
            end
        end
    end

    // Read next-state: one AR beat, then one R beat, then back to idle.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (s0.arvalid || s1.arvalid) r_next = R_ADDR;
            R_ADDR:  if (m.arvalid && m.arready)   r_next = R_DATA;
            R_DATA:  if (m.rvalid && m.rready)     r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    logic [ADDR_WIDTH-1:0] ar_addr;
    assign ar_addr  = r_grant ? s1.araddr : s0.araddr;
    assign m.araddr = ar_addr;
    assign m.arprot = r_grant ? s1.arprot : s0.arprot;
    assign s0.rdata = m.rdata;
    assign s1.rdata = m.rdata;

    // Read outputs: forward AR in R_ADDR and R in R_DATA for the granted port only.
    always_comb begin
        m.arvalid  = 1'b0;
        m.rready   = 1'b0;
        s0.arready = 1'b0;
        s1.arready = 1'b0;
        s0.rvalid  = 1'b0;
        s1.rvalid  = 1'b0;
        case (r_state)
            R_ADDR: begin
                m.arvalid = r_grant ? s1.arvalid : s0.arvalid;
                if (r_grant) s1.arready = m.arready;
                else         s0.arready = m.arready;
            end
            R_DATA: begin
                m.rready = r_grant ? s1.rready : s0.rready;
                if (r_grant) s1.rvalid = m.rvalid;
                else         s0.rvalid = m.rvalid;
            end
            default: ;
        endcase
    end

    // ---------------- write path ----------------
    w_state_t w_next;
    grant_t   w_grant;
    grant_t   w_winner;
    logic     w_load;
    logic     aw_done;
    logic     w_done;
    logic     aw_hs;
    logic     w_hs;

    assign w_load = (w_state == W_IDLE) && (s0.awvalid || s1.awvalid);
    assign aw_hs  = m.awvalid && m.awready;
    assign w_hs   = m.wvalid && m.wready;

    axil_arb2_sel u_wr_sel (
        .clk    (clk),
        .rst    (rst),
        .req0   (s0.awvalid),
        .req1   (s1.awvalid),
        .load   (w_load),
        .winner (w_winner)
    );

    // Write state, grant and per-channel done flags (flags live only within W_XFER).
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_grant <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_next;
            if (w_load) begin
                w_grant <= w_winner;
            end
            if (w_state != W_XFER) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
        end
    end

    // Write next-state: AW and W may finish in either order or together.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (s0.awvalid || s1.awvalid) w_next = W_XFER;
            W_XFER:  if ((aw_done || aw_hs) && (w_done || w_hs)) w_next = W_RESP;
            W_RESP:  if (m.bvalid && m.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    assign w_data   = w_grant ? s1.wdata : s0.wdata;
    assign w_strb   = w_grant ? s1.wstrb : s0.wstrb;
    assign m.awaddr = w_grant ? s1.awaddr : s0.awaddr;
    assign m.awprot = w_grant ? s1.awprot : s0.awprot;
    assign m.wdata  = w_data;
    assign m.wstrb  = w_strb;

    // Write outputs: forward AW/W until each is done, then forward B, granted port only.
    always_comb begin
        m.awvalid  = 1'b0;
        m.wvalid   = 1'b0;
        m.bready   = 1'b0;
        s0.awready = 1'b0;
        s1.awready = 1'b0;
        s0.wready  = 1'b0;
        s1.wready  = 1'b0;
        s0.bvalid  = 1'b0;
        s1.bvalid  = 1'b0;
        case (w_state)
            W_XFER: begin
                m.awvalid = (w_grant ? s1.awvalid : s0.awvalid) && !aw_done;
                m.wvalid  = (w_grant ? s1.wvalid : s0.wvalid) && !w_done;
                if (w_grant) begin
                    s1.awready = m.awready && !aw_done;
                    s1.wready  = m.wready && !w_done;
                end else begin
                    s0.awready = m.awready && !aw_done;
                    s0.wready  = m.wready && !w_done;
                end
            end
            W_RESP: begin
                m.bready = w_grant ? s1.bready : s0.bready;
                if (w_grant) s1.bvalid = m.bvalid;
                else         s0.bvalid = m.bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axil_arb2.sv
// Bench for axil_arb2: two requester drivers, a behavioural AXI-Lite RAM on m,
// and directed scenarios with hand-computed expectations.
module tb_axil_arb2;
    import axil_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_intf s0_if ();
    axil_intf s1_if ();
    axil_intf m_if ();
    r_state_t r_state;
    w_state_t w_state;

    axil_arb2 dut (
        .clk     (clk),
        .rst     (rst),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if),
        .r_state (r_state),
        .w_state (w_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- requester drive signals ----------------
    logic [1:0]       arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
    logic [1:0][31:0] araddr_d, awaddr_d, wdata_d;
    logic [1:0][3:0]  wstrb_d;

    assign s0_if.araddr  = araddr_d[0];
    assign s0_if.arprot  = 3'b000;
    assign s0_if.arvalid = arvalid_d[0];
    assign s0_if.rready  = rready_d[0];
    assign s0_if.awaddr  = awaddr_d[0];
    assign s0_if.awprot  = 3'b000;
    assign s0_if.awvalid = awvalid_d[0];
    assign s0_if.wdata   = wdata_d[0];
    assign s0_if.wstrb   = wstrb_d[0];
    assign s0_if.wvalid  = wvalid_d[0];
    assign s0_if.bready  = bready_d[0];
    assign s1_if.araddr  = araddr_d[1];
    assign s1_if.arprot  = 3'b001;
    assign s1_if.arvalid = arvalid_d[1];
    assign s1_if.rready  = rready_d[1];
    assign s1_if.awaddr  = awaddr_d[1];
    assign s1_if.awprot  = 3'b001;
    assign s1_if.awvalid = awvalid_d[1];
    assign s1_if.wdata   = wdata_d[1];
    assign s1_if.wstrb   = wstrb_d[1];
    assign s1_if.wvalid  = wvalid_d[1];
    assign s1_if.bready  = bready_d[1];

    wire [1:0]       arready_o = {s1_if.arready, s0_if.arready};
    wire [1:0]       rvalid_o  = {s1_if.rvalid, s0_if.rvalid};
    wire [1:0]       awready_o = {s1_if.awready, s0_if.awready};
    wire [1:0]       wready_o  = {s1_if.wready, s0_if.wready};
    wire [1:0]       bvalid_o  = {s1_if.bvalid, s0_if.bvalid};
    wire [1:0][31:0] rdata_o   = {s1_if.rdata, s0_if.rdata};

    wire [14:0] all_vr = {s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
                          s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid,
                          m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready};

    // ---------------- downstream RAM model ----------------
    logic [31:0] mem [0:255];
    logic        ram_rvalid, ram_bvalid, have_aw, have_w;
    logic [31:0] ram_rdata, aw_q, w_q;
    logic [3:0]  s_q;

    wire        m_ar_hs = m_if.arvalid && m_if.arready;
    wire        m_aw_hs = m_if.awvalid && m_if.awready;
    wire        m_w_hs  = m_if.wvalid && m_if.wready;
    wire [31:0] wr_addr = have_aw ? aw_q : m_if.awaddr;
    wire [31:0] wr_data = have_w ? w_q : m_if.wdata;
    wire [3:0]  wr_strb = have_w ? s_q : m_if.wstrb;
    wire        wr_go   = (have_aw || m_aw_hs) && (have_w || m_w_hs);

    assign m_if.arready = !ram_rvalid;
    assign m_if.rvalid  = ram_rvalid;
    assign m_if.rdata   = ram_rdata;
    assign m_if.awready = !have_aw && !ram_bvalid;
    assign m_if.wready  = !have_w && !ram_bvalid;
    assign m_if.bvalid  = ram_bvalid;

    always @(posedge clk) begin
        if (rst) begin
            ram_rvalid <= 1'b0;
            ram_bvalid <= 1'b0;
            have_aw    <= 1'b0;
            have_w     <= 1'b0;
        end else begin
            if (m_ar_hs) begin
                ram_rvalid <= 1'b1;
                ram_rdata  <= mem[m_if.araddr[9:2]];
            end else if (m_if.rvalid && m_if.rready) begin
                ram_rvalid <= 1'b0;
            end
            if (wr_go) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr[9:2]][8*b +: 8] <= wr_data[8*b +: 8];
                ram_bvalid <= 1'b1;
                have_aw    <= 1'b0;
                have_w     <= 1'b0;
            end else begin
                if (m_aw_hs) begin
                    have_aw <= 1'b1;
                    aw_q    <= m_if.awaddr;
                end
                if (m_w_hs) begin
                    have_w <= 1'b1;
                    w_q    <= m_if.wdata;
                    s_q    <= m_if.wstrb;
                end
            end
            if (m_if.bvalid && m_if.bready) ram_bvalid <= 1'b0;
        end
    end

    // ---------------- monitors ----------------
    int rv_cyc [2];
    int bv_cyc [2];
    int b_hs [2];
    int m_b_hs;
    int overlap;
    int s1_act;
    logic [0:0] rd_order[$];
    logic [0:0] b_order[$];
    logic [0:0] exp_q[$];

    always @(posedge clk) begin
        if (s0_if.rvalid) rv_cyc[0] <= rv_cyc[0] + 1;
        if (s1_if.rvalid) rv_cyc[1] <= rv_cyc[1] + 1;
        if (s0_if.bvalid) bv_cyc[0] <= bv_cyc[0] + 1;
        if (s1_if.bvalid) bv_cyc[1] <= bv_cyc[1] + 1;
        if (s0_if.bvalid && s0_if.bready) begin
            b_hs[0] <= b_hs[0] + 1;
            b_order.push_back(1'b0);
        end
        if (s1_if.bvalid && s1_if.bready) begin
            b_hs[1] <= b_hs[1] + 1;
            b_order.push_back(1'b1);
        end
        if (s0_if.rvalid && s0_if.rready) rd_order.push_back(1'b0);
        if (s1_if.rvalid && s1_if.rready) rd_order.push_back(1'b1);
        if (m_if.bvalid && m_if.bready) m_b_hs <= m_b_hs + 1;
        if (r_state != R_IDLE && w_state != W_IDLE) overlap <= overlap + 1;
        if (|{s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid})
            s1_act <= s1_act + 1;
    end

    // ---------------- driver tasks (start and end on a falling edge) ----------------
    task automatic do_read(input int p, input logic [31:0] addr,
                           output logic [31:0] data, output int lat, output bit ok);
        bit hs;
        ok = 1'b1;
        lat = -1;
        data = '0;
        araddr_d[p] = addr;
        arvalid_d[p] = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 80 && !hs; n++) begin
            #1;
            if (arready_o[p]) begin
                hs = 1'b1;
                lat = n;
            end
            @(negedge clk);
        end
        arvalid_d[p] = 1'b0;
        if (!hs) ok = 1'b0;
        rready_d[p] = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 80 && !hs; n++) begin
            #1;
            if (rvalid_o[p]) begin
                hs = 1'b1;
                data = rdata_o[p];
            end
            @(negedge clk);
        end
        rready_d[p] = 1'b0;
        if (!hs) ok = 1'b0;
    endtask

    task automatic do_write(input int p, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead,
                            output bit lead_rdy, output bit ok);
        bit aw_ok, w_ok, hs;
        ok = 1'b1;
        lead_rdy = 1'b0;
        awaddr_d[p] = addr;
        wdata_d[p] = data;
        wstrb_d[p] = strb;
        wvalid_d[p] = 1'b1;
        for (int n = 0; n < lead; n++) begin
            #1;
            if (wready_o[p]) lead_rdy = 1'b1;
            @(negedge clk);
        end
        awvalid_d[p] = 1'b1;
        aw_ok = 1'b0;
        w_ok = 1'b0;
        for (int n = 0; n < 80 && !(aw_ok && w_ok); n++) begin
            #1;
            if (awvalid_d[p] && awready_o[p]) aw_ok = 1'b1;
            if (wvalid_d[p] && wready_o[p]) w_ok = 1'b1;
            @(negedge clk);
            if (aw_ok) awvalid_d[p] = 1'b0;
            if (w_ok) wvalid_d[p] = 1'b0;
        end
        awvalid_d[p] = 1'b0;
        wvalid_d[p] = 1'b0;
        if (!(aw_ok && w_ok)) ok = 1'b0;
        bready_d[p] = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 80 && !hs; n++) begin
            #1;
            if (bvalid_o[p]) hs = 1'b1;
            @(negedge clk);
        end
        bready_d[p] = 1'b0;
        if (!hs) ok = 1'b0;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (all_vr !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 0", all_vr);
        end
        n_cmp++;
        if (r_state !== R_IDLE) begin
            n_err++;
            $display("FAIL reset_r_state: got %0d expected %0d", r_state, R_IDLE);
        end
        n_cmp++;
        if (w_state !== W_IDLE) begin
            n_err++;
            $display("FAIL reset_w_state: got %0d expected %0d", w_state, W_IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_preload;
        bit ok, lr, all_ok;
        all_ok = 1'b1;
        do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, lr, ok); all_ok &= ok;
        do_write(0, 32'h30, 32'h30303030, 4'hF, 0, lr, ok); all_ok &= ok;
        do_write(1, 32'h60, 32'hAABBCCDD, 4'hF, 0, lr, ok); all_ok &= ok;
        for (int i = 0; i < 4; i++) begin
            do_write(0, 32'h100 + 4 * i, 32'hA000_0000 + i, 4'hF, 0, lr, ok); all_ok &= ok;
            do_write(1, 32'h200 + 4 * i, 32'hB000_0000 + i, 4'hF, 0, lr, ok); all_ok &= ok;
        end
        n_cmp++;
        if (all_ok !== 1'b1) begin
            n_err++;
            $display("FAIL preload_writes: got ok=%0d expected 1", all_ok);
        end
    endtask

    task automatic test_single_read;
        logic [31:0] d;
        int lat, act0;
        bit ok;
        act0 = s1_act;
        do_read(0, 32'h10, d, lat, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL single_read_done: got %0d expected 1", ok); end
        n_cmp++;
        if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_read_data: got %h expected deadbeef", d); end
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL single_read_latency: got %0d expected 1", lat); end
        n_cmp++;
        if (s1_act - act0 !== 0) begin n_err++; $display("FAIL single_read_s1_quiet: got %0d active cycles expected 0", s1_act - act0); end
    endtask

    task automatic test_tie;
        bit ok0, ok1, lr0, lr1, okr;
        int base, lat;
        logic [31:0] d;
        pulse_reset();
        base = b_order.size();
        fork
            do_write(0, 32'h20, 32'h11111111, 4'hF, 0, lr0, ok0);
            do_write(1, 32'h20, 32'h22222222, 4'hF, 0, lr1, ok1);
        join
        n_cmp++;
        if ({ok0, ok1} !== 2'b11) begin n_err++; $display("FAIL tie_done: got %b expected 11", {ok0, ok1}); end
        n_cmp++;
        if (b_order.size() - base !== 2) begin
            n_err++;
            $display("FAIL tie_resp_count: got %0d expected 2", b_order.size() - base);
        end else begin
            n_cmp++;
            if (b_order[base] !== 1'b0 || b_order[base + 1] !== 1'b1) begin
                n_err++;
                $display("FAIL tie_order: got %0d,%0d expected 0,1", b_order[base], b_order[base + 1]);
            end
        end
        do_read(0, 32'h20, d, lat, okr);
        n_cmp++;
        if (d !== 32'h22222222) begin n_err++; $display("FAIL tie_final_data: got %h expected 22222222", d); end
    endtask

    logic [31:0] rr_d0 [4];
    logic [31:0] rr_d1 [4];
    bit          rr_ok [8];

    task automatic test_back_to_back;
        int base, lat0, lat1;
        pulse_reset();
        base = rd_order.size();
        exp_q.delete();
`ifdef AXIL_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(1'b0);
            exp_q.push_back(1'b1);
        end
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
`endif
        fork
            begin
                for (int i = 0; i < 4; i++) do_read(0, 32'h100 + 4 * i, rr_d0[i], lat0, rr_ok[i]);
            end
            begin
                for (int i = 0; i < 4; i++) do_read(1, 32'h200 + 4 * i, rr_d1[i], lat1, rr_ok[4 + i]);
            end
        join
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rr_d0[i] !== 32'hA000_0000 + i || !rr_ok[i]) begin
                n_err++;
                $display("FAIL b2b_s0_data[%0d]: got %h expected %h", i, rr_d0[i], 32'hA000_0000 + i);
            end
            n_cmp++;
            if (rr_d1[i] !== 32'hB000_0000 + i || !rr_ok[4 + i]) begin
                n_err++;
                $display("FAIL b2b_s1_data[%0d]: got %h expected %h", i, rr_d1[i], 32'hB000_0000 + i);
            end
        end
        n_cmp++;
        if (rd_order.size() - base !== 8) begin
            n_err++;
            $display("FAIL b2b_count: got %0d expected 8", rd_order.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (rd_order[base + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL b2b_order[%0d]: got s%0d expected s%0d", i, rd_order[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_skewed_write;
        int mb0, b0, b1, lat;
        bit ok, lr, okr;
        logic [31:0] d;
        mb0 = m_b_hs;
        b0 = b_hs[0];
        b1 = b_hs[1];
        do_write(1, 32'h60, 32'h11223344, 4'b0011, 3, lr, ok);
        @(negedge clk);
        n_cmp++;
        if (lr !== 1'b0) begin n_err++; $display("FAIL skew_early_wready: got %0d expected 0", lr); end
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL skew_done: got %0d expected 1", ok); end
        n_cmp++;
        if (m_b_hs - mb0 !== 1) begin n_err++; $display("FAIL skew_write_count: got %0d expected 1", m_b_hs - mb0); end
        n_cmp++;
        if (b_hs[1] - b1 !== 1 || b_hs[0] - b0 !== 0) begin
            n_err++;
            $display("FAIL skew_b_route: got s0=%0d s1=%0d expected s0=0 s1=1", b_hs[0] - b0, b_hs[1] - b1);
        end
        do_read(1, 32'h60, d, lat, okr);
        n_cmp++;
        if (d !== 32'hAABB3344) begin n_err++; $display("FAIL skew_data: got %h expected aabb3344", d); end
    endtask

    task automatic test_concurrent;
        int ov0, rv1, bv0, lat;
        bit okr, okw, lr, ok2;
        logic [31:0] d, d2;
        ov0 = overlap;
        rv1 = rv_cyc[1];
        bv0 = bv_cyc[0];
        fork
            do_read(0, 32'h30, d, lat, okr);
            do_write(1, 32'h40, 32'h40404040, 4'hF, 0, lr, okw);
        join
        n_cmp++;
        if (d !== 32'h30303030 || !okr) begin n_err++; $display("FAIL conc_read_data: got %h expected 30303030", d); end
        n_cmp++;
        if (okw !== 1'b1) begin n_err++; $display("FAIL conc_write_done: got %0d expected 1", okw); end
        n_cmp++;
        if (overlap - ov0 <= 0) begin n_err++; $display("FAIL conc_overlap: got %0d cycles expected >0", overlap - ov0); end
        n_cmp++;
        if (rv_cyc[1] - rv1 !== 0 || bv_cyc[0] - bv0 !== 0) begin
            n_err++;
            $display("FAIL conc_cross_route: got s1_rvalid=%0d s0_bvalid=%0d expected 0,0", rv_cyc[1] - rv1, bv_cyc[0] - bv0);
        end
        do_read(0, 32'h40, d2, lat, ok2);
        n_cmp++;
        if (d2 !== 32'h40404040) begin n_err++; $display("FAIL conc_write_data: got %h expected 40404040", d2); end
    endtask

    task automatic test_reset_mid;
        bit hs, reached, ok;
        int lat;
        logic [31:0] d;
        araddr_d[0] = 32'h10;
        arvalid_d[0] = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 20 && !hs; n++) begin
            #1;
            if (arready_o[0]) hs = 1'b1;
            @(negedge clk);
        end
        arvalid_d[0] = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 20 && !reached; n++) begin
            #1;
            if (r_state == R_DATA && m_if.rvalid) reached = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (reached !== 1'b1) begin n_err++; $display("FAIL midrst_reach_rdata: got %0d expected 1", reached); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (all_vr !== 15'd0) begin n_err++; $display("FAIL midrst_outputs: got %b expected 0", all_vr); end
        n_cmp++;
        if (r_state !== R_IDLE) begin n_err++; $display("FAIL midrst_r_state: got %0d expected %0d", r_state, R_IDLE); end
        rst = 1'b0;
        @(negedge clk);
        do_read(1, 32'h10, d, lat, ok);
        n_cmp++;
        if (d !== 32'hDEADBEEF || !ok) begin n_err++; $display("FAIL midrst_s1_read: got %h expected deadbeef", d); end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        arvalid_d = '0;
        rready_d  = '0;
        awvalid_d = '0;
        wvalid_d  = '0;
        bready_d  = '0;
        araddr_d  = '0;
        awaddr_d  = '0;
        wdata_d   = '0;
        wstrb_d   = '0;
        test_reset();
        test_preload();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_skewed_write();
        test_concurrent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axil_arb2.md
AXIL_ARB2 -- requirements
Module: axil_arb2

Interface
REQ-001 SHALL have parameters DATA_WIDTH (default axil_pkg::DATA_WIDTH, data bus width) and ADDR_WIDTH (default axil_pkg::ADDR_WIDTH, address width).
REQ-002 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port s0, axil_intf (slave side), -, requester 0 (highest static priority).
REQ-005 SHALL have port s1, axil_intf (slave side), -, requester 1.
REQ-006 SHALL have port m, axil_intf (master side), -, shared downstream port to the AXI-Lite RAM wrapper.
REQ-007 SHALL use these signals on each port: aw/ar addr, prot, valid, ready; wdata, wstrb, wvalid, wready; bvalid, bready; rdata, rvalid, rready; response codes are not carried.

Function
REQ-008 SHALL arbitrate the read path and the write path independently, each with its own FSM and grant.
REQ-009 Read FSM SHALL have states R_IDLE, R_ADDR and R_DATA.
- R_IDLE -> R_ADDR when any s*.arvalid=1; the grant is registered this cycle.
- R_ADDR -> R_DATA on m.arvalid & m.arready.
- R_DATA -> R_IDLE on m.rvalid & m.rready.
REQ-010 In R_ADDR, m.araddr/arprot/arvalid SHALL equal the granted port's signals, and the granted port's arready SHALL equal m.arready.
REQ-011 In R_DATA, the granted port's rdata/rvalid SHALL equal m's, and m.rready SHALL equal the granted port's rready.
REQ-012 Write FSM SHALL have states W_IDLE, W_XFER and W_RESP.
- W_IDLE -> W_XFER when any s*.awvalid=1.
- W_XFER -> W_RESP once both the AW and W handshakes are complete (aw_done, w_done flags; they may complete in the same cycle or in either order).
- W_RESP -> W_IDLE on m.bvalid & m.bready.
REQ-013 In W_XFER, m.awvalid SHALL be granted awvalid & !aw_done, and m.wvalid SHALL be granted wvalid & !w_done; the granted port's readies SHALL mirror m's and be gated by the same done flags.
REQ-014 In W_RESP, the granted port's bvalid SHALL equal m.bvalid, and m.bready SHALL equal the granted port's bready.
REQ-015 All ready/valid outputs toward a non-granted port, and all m valids outside the forwarding states, SHALL be 0; m.rready and m.bready SHALL be 0 outside R_DATA and W_RESP.
REQ-016 Grant-to-first-m-valid latency SHALL be exactly 1 cycle; the arbiter SHALL insert no other bubbles.
REQ-017 At most one transaction SHALL be outstanding per path; a read and a write may be in flight concurrently.
REQ-018 A request arriving mid-transaction SHALL be held (its ready stays 0) until the FSM returns to IDLE; the grant SHALL NOT change between the IDLE exit and the return to IDLE.
REQ-019 On simultaneous requests, the arbitration rule of REQ-023/024 SHALL decide the grant.

Reset
REQ-020 While rst=1, both FSMs SHALL go to IDLE, aw_done and w_done SHALL be 0, and the grants SHALL be 0.
REQ-021 On reset, all valid and ready outputs on s0, s1 and m SHALL be 0 the cycle after rst is sampled high; an in-flight transaction is abandoned, not completed.
REQ-022 With round-robin enabled, the last-grant pointers SHALL reset to 1, so s0 wins the first tie.

Configuration
REQ-023 With AXIL_ARB_RR_EN defined, each path SHALL use round-robin: on a tie, grant the port not granted last; the pointer updates on each IDLE exit.
REQ-024 Without AXIL_ARB_RR_EN, each path SHALL use fixed priority: s0 always wins ties, and no pointer flops are generated.

Structure
REQ-025 The read state enum, the write state enum and the grant type SHALL live in axil_pkg alongside DATA_WIDTH and ADDR_WIDTH.
REQ-026 A sub-module axil_arb2_sel (2-way grant select, with the optional round-robin pointer) SHALL be instantiated once per path.

Verification
REQ-027 Single read: s0 reads addr 0x10 holding 0xDEADBEEF -> s0.rdata=0xDEADBEEF; s1 sees no valids; m.arvalid rises 1 cycle after s0.arvalid.
REQ-028 Tie: s0 and s1 write 0x11111111 and 0x22222222 to 0x20 in the same cycle -> s0 is served first; the final read of 0x20 returns 0x22222222.
REQ-029 RR fairness (AXIL_ARB_RR_EN): both ports issue 4 back-to-back reads -> grants alternate s0,s1,s0,s1,... With the macro undefined -> all of s0's reads complete before s1's first.
REQ-030 Skewed write channels: s1 asserts wvalid 3 cycles before awvalid, with wstrb=4'b0011 onto 0xAABBCCDD -> the write completes once, only the low 2 bytes change, and bvalid is routed to s1.
REQ-031 Concurrency: s0 reads 0x30 while s1 writes 0x40 -> both complete with overlapping cycles, and there is no cross-routing of rvalid or bvalid.
REQ-032 Reset mid-op: rst pulsed in R_DATA with rready=0 -> the next cycle all outputs are 0, the FSM is in R_IDLE, and a new s1 read then succeeds.
